// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard and forwarding controller for the in-order integer pipeline.
//   Tracks in-flight register writes in a shift register that mirrors the
//   ID/EX .. MEM/WB positions. It produces a combinational decode stall and
//   a registered forward select for each EX operand mux.
//
// Optional feature macro: HAZARD_SCOREBOARD_PERF_EN
//   When it is defined, the block adds the stall_cnt_o and fwd_cnt_o
//   performance counters.
//
// Ports
//   clk_i          clock
//   rstn_i         asynchronous reset, active low
//   issue_valid_i  decode holds a valid instruction
//   issue_rd_i     destination register
//   issue_rd_wr_i  the instruction writes rd
//   issue_lat_i    first position whose bus carries the result (ALU=2, load=3)
//   src_idx_i      source register indices, src0 in the LSBs
//   src_used_i     per-source "actually read" flags
//   flush_i        taken branch: kill the instruction in decode
//   hold_i         downstream stall: freeze all state
//   stall_o        hold fetch/decode this cycle (combinational)
//   fwd_sel_o      per-source select for the instruction in EX
//                  (0 = regfile, k = position-k bus)
//   stall_cnt_o    hazard stall cycles            (HAZARD_SCOREBOARD_PERF_EN)
//   fwd_cnt_o      accepted issues that forward   (HAZARD_SCOREBOARD_PERF_EN)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter  int NUM_STAGES = 3,
   parameter  int NUM_SRC    = 2,
   parameter  int REG_ADDR_W = 5,
   localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          issue_valid_i,
   input  logic [REG_ADDR_W-1:0]         issue_rd_i,
   input  logic                          issue_rd_wr_i,
   input  logic [SEL_W-1:0]              issue_lat_i,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_idx_i,
   input  logic [NUM_SRC-1:0]            src_used_i,
   input  logic                          flush_i,
   input  logic                          hold_i,
   output logic                          stall_o,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o
`ifdef HAZARD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]                   stall_cnt_o,
   output logic [31:0]                   fwd_cnt_o
`endif
);

   // Only positions 1..NUM_STAGES-1 are stored. An entry that reaches
   // position NUM_STAGES can never cause a stall or a forward, because the
   // regfile is write-first. Dropping it gives the same behaviour as
   // retiring it.
   localparam int LAST = NUM_STAGES - 1;

   logic                  valid_q [1:LAST];
   logic                  valid_d [1:LAST];
   logic [REG_ADDR_W-1:0] rd_q    [1:LAST];
   logic [REG_ADDR_W-1:0] rd_d    [1:LAST];
   logic [SEL_W-1:0]      lat_q   [1:LAST];
   logic [SEL_W-1:0]      lat_d   [1:LAST];

   logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
   logic [NUM_SRC*SEL_W-1:0] sel_calc;
   logic [NUM_SRC-1:0]       src_stall;
   logic [SEL_W-1:0]         lat_clamped;
   logic                     hazard_stall;
   logic                     accept;

   // Clamp the requested latency into the range [2, NUM_STAGES].
   always_comb begin
      lat_clamped = issue_lat_i;
      if (int'(issue_lat_i) < 2) begin
         lat_clamped = SEL_W'(2);
      end else if (int'(issue_lat_i) > NUM_STAGES) begin
         lat_clamped = SEL_W'(NUM_STAGES);
      end
   end

   // Source lookup. Positions are scanned from oldest to youngest, and each
   // hit overwrites the previous result, so the youngest matching writer
   // decides the outcome. A producer seen at position p sits at p+1 by the
   // time the consumer reaches EX.
   always_comb begin
      sel_calc  = '0;
      src_stall = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int p = LAST; p >= 1; p--) begin
            if (src_used_i[s] &&
                (src_idx_i[s*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                valid_q[p] &&
                (rd_q[p] == src_idx_i[s*REG_ADDR_W +: REG_ADDR_W])) begin
               if ((p + 1) >= int'(lat_q[p])) begin
                  sel_calc[s*SEL_W +: SEL_W] = SEL_W'(p + 1);
                  src_stall[s]               = 1'b0;
               end else begin
                  sel_calc[s*SEL_W +: SEL_W] = '0;
                  src_stall[s]               = 1'b1;
               end
            end
         end
      end
   end

   // A flush overrides a hazard stall. A hold stalls decode unconditionally.
   assign hazard_stall = issue_valid_i & ~flush_i & (|src_stall);
   assign stall_o      = hold_i | hazard_stall;
   assign accept       = issue_valid_i & ~hazard_stall & ~flush_i & ~hold_i;

   // Next state. When accept is low, position 1 receives a bubble and EX
   // receives all-zero selects.
   always_comb begin
      valid_d[1] = accept & issue_rd_wr_i & (issue_rd_i != '0);
      rd_d[1]    = issue_rd_i;
      lat_d[1]   = lat_clamped;
      for (int p = 2; p <= LAST; p++) begin
         valid_d[p] = valid_q[p-1];
         rd_d[p]    = rd_q[p-1];
         lat_d[p]   = lat_q[p-1];
      end
      fwd_sel_d = accept ? sel_calc : '0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int p = 1; p <= LAST; p++) begin
            valid_q[p] <= 1'b0;
            rd_q[p]    <= '0;
            lat_q[p]   <= '0;
         end
         fwd_sel_q <= '0;
      end else if (!hold_i) begin
         for (int p = 1; p <= LAST; p++) begin
            valid_q[p] <= valid_d[p];
            rd_q[p]    <= rd_d[p];
            lat_q[p]   <= lat_d[p];
         end
         fwd_sel_q <= fwd_sel_d;
      end
   end

   assign fwd_sel_o = fwd_sel_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] fwd_cnt_q;
   logic [31:0] fwd_cnt_d;

   // Both counters wrap naturally at 2^32.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (!hold_i && hazard_stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (accept && (|sel_calc)) begin
         fwd_cnt_d = fwd_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard (NUM_STAGES=3, NUM_SRC=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hazard_scoreboard;

   localparam int NS = 3;
   localparam int NSRC = 2;
   localparam int AW = 5;
   localparam int SW = 2;

   logic            clk;
   logic            rstn;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic            issue_rd_wr;
   logic [SW-1:0]   issue_lat;
   logic [NSRC*AW-1:0] src_idx;
   logic [NSRC-1:0] src_used;
   logic            flush;
   logic            hold;
   logic            stall;
   logic [NSRC*SW-1:0] fwd_sel;
`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0]     stall_cnt;
   logic [31:0]     fwd_cnt;
`endif

   int total = 0;
   int bad   = 0;

   hazard_scoreboard #(
      .NUM_STAGES (NS),
      .NUM_SRC    (NSRC),
      .REG_ADDR_W (AW)
   ) dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .issue_rd_wr_i (issue_rd_wr),
      .issue_lat_i   (issue_lat),
      .src_idx_i     (src_idx),
      .src_used_i    (src_used),
      .flush_i       (flush),
      .hold_i        (hold),
      .stall_o       (stall),
      .fwd_sel_o     (fwd_sel)
`ifdef HAZARD_SCOREBOARD_PERF_EN
      ,
      .stall_cnt_o   (stall_cnt),
      .fwd_cnt_o     (fwd_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic set_issue(input logic v, input logic [AW-1:0] rd, input logic wr,
                            input logic [SW-1:0] lat, input logic [AW-1:0] s0,
                            input logic [AW-1:0] s1, input logic [1:0] used,
                            input logic fl, input logic hd);
      issue_valid = v;
      issue_rd    = rd;
      issue_rd_wr = wr;
      issue_lat   = lat;
      src_idx     = {s1, s0};
      src_used    = used;
      flush       = fl;
      hold        = hd;
   endtask

   task automatic set_idle();
      set_issue(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic drain();
      set_idle();
      repeat (NS + 1) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      set_idle();
      #2;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b want=0000", fwd_sel); end
`ifdef HAZARD_SCOREBOARD_PERF_EN
      total++;
      if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin
         bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, fwd_cnt);
      end
`endif
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // ALU producer followed immediately by a consumer: no stall, forward from position 2
   task automatic test_alu_forward();
      set_issue(1'b1, 5'd5, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL alu_prod_stall got=%0b want=0", stall); end
      @(negedge clk);
      set_issue(1'b1, 5'd9, 1'b1, 2'd2, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL alu_use_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL alu_use_fwd got=%b want=0010", fwd_sel); end
      drain();
   endtask

   // load followed by a consumer: one stall cycle with a bubble, then forward from position 3
   task automatic test_load_use();
      set_issue(1'b1, 5'd7, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%0b want=1", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL load_use_bubble got=%b want=0000", fwd_sel); end
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL load_use_release got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b1100) begin bad++; $display("FAIL load_use_fwd got=%b want=1100", fwd_sel); end
      drain();
   endtask

   // older load and younger ALU both write x3: the younger one supplies the forward
   task automatic test_youngest();
      set_issue(1'b1, 5'd3, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd3, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL youngest_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL youngest_fwd got=%b want=0010", fwd_sel); end
      drain();
   endtask

   // x0 destination, a non-writing producer, and an unused source never cause a hazard
   task automatic test_x0_and_unused();
      set_issue(1'b1, 5'd0, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL x0_fwd got=%b want=0000", fwd_sel); end
      set_issue(1'b1, 5'd9, 1'b0, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL nowr_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL nowr_fwd got=%b want=0000", fwd_sel); end
      set_issue(1'b1, 5'd10, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd10, 5'd10, 2'b00, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL unused_stall got=%0b want=0", stall); end
      drain();
   endtask

   // a latency below 2 is clamped to 2; producer distance 2 -> select 3; distance 3 -> regfile
   task automatic test_distance_and_clamp();
      set_issue(1'b1, 5'd4, 1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd0, 5'd4, 2'b10, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL clamp_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b1000) begin bad++; $display("FAIL clamp_fwd got=%b want=1000", fwd_sel); end
      set_issue(1'b1, 5'd7, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd7, 5'd0, 2'b01, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL dist2_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0011) begin bad++; $display("FAIL dist2_fwd got=%b want=0011", fwd_sel); end
      set_issue(1'b1, 5'd8, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL dist3_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL dist3_fwd got=%b want=0000", fwd_sel); end
      drain();
   endtask

   // flush overrides a stall; hold overrides flush and freezes all state
   task automatic test_flush_hold();
      set_issue(1'b1, 5'd7, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd7, 5'd0, 2'b01, 1'b1, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL flush_fwd got=%b want=0000", fwd_sel); end
      drain();
      set_issue(1'b1, 5'd5, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd7, 1'b1, 2'd3, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL pre_hold_fwd got=%b want=0010", fwd_sel); end
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd0, 5'd7, 2'b10, 1'b1, 1'b1);
      #1;
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL hold_stall got=%0b want=1", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL hold_frozen_fwd got=%b want=0010", fwd_sel); end
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL hold_frozen_entry got=%0b want=1", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL post_hold_bubble got=%b want=0000", fwd_sel); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b1100) begin bad++; $display("FAIL post_hold_fwd got=%b want=1100", fwd_sel); end
      drain();
   endtask

   // asynchronous reset while two entries are live
   task automatic test_reset_mid();
      set_issue(1'b1, 5'd5, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      set_issue(1'b1, 5'd6, 1'b1, 2'd2, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL pre_rst_fwd got=%b want=0010", fwd_sel); end
      set_idle();
      rstn = 1'b0;
      #1;
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL mid_rst_fwd got=%b want=0000", fwd_sel); end
      @(negedge clk);
      rstn = 1'b1;
      set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd6, 5'd5, 2'b11, 1'b0, 1'b0);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%0b want=0", stall); end
      @(negedge clk);
      total++;
      if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL post_rst_fwd got=%b want=0000", fwd_sel); end
      drain();
   endtask

`ifdef HAZARD_SCOREBOARD_PERF_EN
   // three load-use pairs after a reset: three hazard stalls and three forwarding issues
   task automatic test_perf();
      rstn = 1'b0;
      set_idle();
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_issue(1'b1, 5'd7, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
         @(negedge clk);
         set_issue(1'b1, 5'd0, 1'b0, 2'd2, 5'd7, 5'd0, 2'b01, 1'b0, 1'b0);
         @(negedge clk);
         @(negedge clk);
      end
      set_idle();
      total++;
      if (stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_stall_cnt got=%0d want=3", stall_cnt); end
      total++;
      if (fwd_cnt !== 32'd3) begin bad++; $display("FAIL perf_fwd_cnt got=%0d want=3", fwd_cnt); end
      drain();
   endtask
`endif

   initial begin
      set_idle();
      test_reset();
      test_alu_forward();
      test_load_use();
      test_youngest();
      test_x0_and_unused();
      test_distance_and_clamp();
      test_flush_hold();
      test_reset_mid();
`ifdef HAZARD_SCOREBOARD_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
